// File: rtl/tri_raster_stream_if.sv
// Command and pixel-stream bundle between vertex setup, the rasterizer and the
// framebuffer write arbiter. slave = rasterizer side, master = driver side.
interface tri_raster_stream_if #(parameter int COORD_W = 32);
  logic                 i_start;
  logic [2*COORD_W-1:0] i_v1, i_v2, i_v3;
  logic [1:0]           i_cull_mode;
  logic                 o_done;
  logic                 o_culled;
  logic                 o_valid;
  logic                 i_ready;
  logic [31:0]          o_point;

  modport slave  (input  i_start, i_v1, i_v2, i_v3, i_cull_mode, i_ready,
                  output o_done, o_culled, o_valid, o_point);
  modport master (output i_start, i_v1, i_v2, i_v3, i_cull_mode, i_ready,
                  input  o_done, o_culled, o_valid, o_point);
endinterface

// File: rtl/tri_raster_stream.sv
// Triangle scan converter: walks the screen-clipped bounding box row-major with
// incremental edge functions and streams covered pixels over valid/ready.
module tri_raster_stream #(
  parameter int COORD_W       = 32,
  parameter int FRAC_BITS     = 4,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int TOP_LEFT      = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  tri_raster_stream_if.slave bus
);
  localparam int AW = 2*COORD_W;
  typedef logic signed [COORD_W-1:0] crd_t;
  typedef logic signed [AW-1:0]      acc_t;
  typedef enum logic [2:0] {IDLE, SETUP, ORDER, INIT, SCAN, DRAIN} state_t;

  localparam acc_t FMASK = acc_t'((1 << FRAC_BITS) - 1);
  localparam acc_t SCR_W = acc_t'(SCREEN_WIDTH);
  localparam acc_t SCR_H = acc_t'(SCREEN_HEIGHT);

  state_t      state_q, state_d;
  crd_t        vx_q [3], vx_d [3], vy_q [3], vy_d [3];
  logic [1:0]  cull_q, cull_d;
  logic        wpos_q, wpos_d;
  acc_t        e_q [3], e_d [3], erow_q [3], erow_d [3];
  acc_t        dx_q [3], dx_d [3], dy_q [3], dy_d [3];
  logic [15:0] x_q, x_d, y_q, y_d, minx_q, minx_d, maxx_q, maxx_d, maxy_q, maxy_d;
  logic        valid_q, valid_d, culled_q, culled_d;
  logic [31:0] point_q, point_d;

  acc_t ex [3], ey [3], cdx [3], cdy [3], einit [3];
  acc_t w, bminx, bmaxx, bminy, bmaxy;
  logic [2:0] edge_ok;
  logic cull, stall, covered, last_col, last_row;

  function automatic acc_t ceil_px(acc_t v);
    return (v + FMASK) >>> FRAC_BITS;
  endfunction
  function automatic acc_t min3(acc_t a, acc_t b, acc_t c);
    acc_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction
  function automatic acc_t max3(acc_t a, acc_t b, acc_t c);
    acc_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      ex[i] = acc_t'(vx_q[i]);
      ey[i] = acc_t'(vy_q[i]);
    end
    w = (ey[1] - ey[0]) * (ex[2] - ex[1]) - (ex[1] - ex[0]) * (ey[2] - ey[1]);
    cull = (w == 0) || (cull_q == 2'd1 && w > 0) || (cull_q == 2'd2 && w < 0);

    bminx = ceil_px(min3(ex[0], ex[1], ex[2]));
    bminy = ceil_px(min3(ey[0], ey[1], ey[2]));
    bmaxx = ceil_px(max3(ex[0], ex[1], ex[2]));
    bmaxy = ceil_px(max3(ey[0], ey[1], ey[2]));
    if (bminx < 0)     bminx = '0;
    if (bminy < 0)     bminy = '0;
    if (bmaxx > SCR_W) bmaxx = SCR_W;
    if (bmaxy > SCR_H) bmaxy = SCR_H;

    // Edges run v1->v2, v2->v3, v3->v1; edge value is sampled at integer pixel corners.
    for (int i = 0; i < 3; i++) begin
      cdx[i]   = ex[(i == 2) ? 0 : i + 1] - ex[i];
      cdy[i]   = ey[(i == 2) ? 0 : i + 1] - ey[i];
      einit[i] = cdx[i] * ((bminy <<< FRAC_BITS) - ey[i])
               - cdy[i] * ((bminx <<< FRAC_BITS) - ex[i]);
      edge_ok[i] = (e_q[i] > 0) ||
                   ((TOP_LEFT != 0) && (e_q[i] == 0) &&
                    ((dy_q[i] < 0) || (dy_q[i] == 0 && dx_q[i] > 0)));
    end
    covered  = &edge_ok;
    stall    = valid_q && !bus.i_ready;
    last_col = (x_q + 16'd1 == maxx_q);
    last_row = (y_q + 16'd1 == maxy_q);
  end

  always_comb begin
    state_d = state_q;
    vx_d = vx_q;  vy_d = vy_q;  cull_d = cull_q;  wpos_d = wpos_q;
    e_d = e_q;  erow_d = erow_q;  dx_d = dx_q;  dy_d = dy_q;
    x_d = x_q;  y_d = y_q;  minx_d = minx_q;  maxx_d = maxx_q;  maxy_d = maxy_q;
    valid_d = valid_q;  point_d = point_q;  culled_d = 1'b0;
    case (state_q)
      IDLE: if (bus.i_start) begin
        vx_d[0] = bus.i_v1[COORD_W-1:0];  vy_d[0] = bus.i_v1[AW-1:COORD_W];
        vx_d[1] = bus.i_v2[COORD_W-1:0];  vy_d[1] = bus.i_v2[AW-1:COORD_W];
        vx_d[2] = bus.i_v3[COORD_W-1:0];  vy_d[2] = bus.i_v3[AW-1:COORD_W];
        cull_d  = bus.i_cull_mode;
        state_d = SETUP;
      end
      SETUP: begin
        if (cull) begin
          culled_d = 1'b1;
          state_d  = IDLE;
        end else begin
          wpos_d  = (w > 0);
          state_d = ORDER;
        end
      end
      ORDER: begin
        if (wpos_q) begin
          vx_d[1] = vx_q[2];  vy_d[1] = vy_q[2];
          vx_d[2] = vx_q[1];  vy_d[2] = vy_q[1];
        end
        state_d = INIT;
      end
      INIT: begin
        if (bminx >= bmaxx || bminy >= bmaxy) begin
          state_d = IDLE;
        end else begin
          for (int i = 0; i < 3; i++) begin
            dx_d[i] = cdx[i];  dy_d[i] = cdy[i];
            e_d[i]  = einit[i];  erow_d[i] = einit[i];
          end
          x_d = bminx[15:0];  y_d = bminy[15:0];  minx_d = bminx[15:0];
          maxx_d = bmaxx[15:0];  maxy_d = bmaxy[15:0];
          state_d = SCAN;
        end
      end
      SCAN: if (!stall) begin
        valid_d = covered;
        if (covered) point_d = {y_q, x_q};
        if (last_col && last_row) begin
          state_d = DRAIN;
        end else if (last_col) begin
          x_d = minx_q;
          y_d = y_q + 16'd1;
          for (int i = 0; i < 3; i++) begin
            e_d[i]    = erow_q[i] + (dx_q[i] <<< FRAC_BITS);
            erow_d[i] = erow_q[i] + (dx_q[i] <<< FRAC_BITS);
          end
        end else begin
          x_d = x_q + 16'd1;
          for (int i = 0; i < 3; i++) e_d[i] = e_q[i] - (dy_q[i] <<< FRAC_BITS);
        end
      end
      DRAIN: if (!valid_q || bus.i_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      culled_q <= 1'b0;
      point_q  <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      culled_q <= culled_d;
      point_q  <= point_d;
    end
  end

  // Datapath registers are only meaningful once the FSM loads them.
  always_ff @(posedge i_clk) begin
    vx_q <= vx_d;  vy_q <= vy_d;  cull_q <= cull_d;  wpos_q <= wpos_d;
    e_q <= e_d;  erow_q <= erow_d;  dx_q <= dx_d;  dy_q <= dy_d;
    x_q <= x_d;  y_q <= y_d;  minx_q <= minx_d;  maxx_q <= maxx_d;  maxy_q <= maxy_d;
  end

  assign bus.o_done   = (state_q == IDLE);
  assign bus.o_culled = culled_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_point  = point_q;
endmodule

// File: tb/tb_tri_raster_stream.sv
// Scoreboard bench: stimulus pushes hand-computed pixels, negedge monitor pops on handshakes.
module tb_tri_raster_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tri_raster_stream_if #(.COORD_W(32)) busA ();
  tri_raster_stream_if #(.COORD_W(32)) busB ();

  tri_raster_stream #(.TOP_LEFT(1)) dutA (.i_clk(clk), .i_rst(rst), .bus(busA));
  tri_raster_stream #(.TOP_LEFT(0)) dutB (.i_clk(clk), .i_rst(rst), .bus(busB));

  int checks = 0;
  int failures = 0;
  logic [31:0] qA [$];
  logic [31:0] qB [$];
  bit          mon_en = 1'b0;
  bit          held [2];
  logic [31:0] held_pt [2];
  int          acc [2];

  int t10x [10] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
  int t10y [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] mkv(input int x, input int y);
    logic [31:0] xf, yf;
    xf = x * 16;
    yf = y * 16;
    return {yf, xf};
  endfunction

  task automatic push10();
    for (int i = 0; i < 10; i++) qA.push_back({16'(t10y[i]), 16'(t10x[i])});
  endtask

  task automatic mon(input bit sel);
    logic v, r;
    logic [31:0] p, e;
    int n;
    v = sel ? busB.o_valid : busA.o_valid;
    r = sel ? busB.i_ready : busA.i_ready;
    p = sel ? busB.o_point : busA.o_point;
    if (held[sel]) begin
      chk("stall_valid", {31'd0, v}, 32'd1);
      chk("stall_point", p, held_pt[sel]);
    end
    held[sel] = 1'b0;
    if (v && r) begin
      acc[sel]++;
      n = sel ? qB.size() : qA.size();
      if (n == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_pixel dut=%0d got=%0h required=none", sel, p);
      end else begin
        if (sel) e = qB.pop_front(); else e = qA.pop_front();
        chk(sel ? "pixel_B" : "pixel_A", p, e);
      end
    end else if (v) begin
      held[sel]    = 1'b1;
      held_pt[sel] = p;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      mon(1'b0);
      mon(1'b1);
    end
  end

  task automatic start_tri(input bit sel, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic [1:0] cm);
    @(posedge clk); #1;
    if (sel) begin
      busB.i_v1 = a; busB.i_v2 = b; busB.i_v3 = c; busB.i_cull_mode = cm; busB.i_start = 1'b1;
    end else begin
      busA.i_v1 = a; busA.i_v2 = b; busA.i_v3 = c; busA.i_cull_mode = cm; busA.i_start = 1'b1;
    end
    @(posedge clk); #1;
    busA.i_start = 1'b0;
    busB.i_start = 1'b0;
  endtask

  // Returns the cycle number (start cycle = 0) in which o_done is first seen high.
  task automatic wait_done(input bit sel, input int limit, output int n);
    n = 1;
    @(negedge clk);
    while (!(sel ? busB.o_done : busA.o_done) && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic expect_culled(input string nm);
    @(negedge clk);
    chk({nm, "_c1_culled"}, {31'd0, busA.o_culled}, 32'd0);
    @(negedge clk);
    chk({nm, "_c2_culled"}, {31'd0, busA.o_culled}, 32'd1);
    chk({nm, "_c2_done"},   {31'd0, busA.o_done},   32'd1);
    @(negedge clk);
    chk({nm, "_c3_culled"}, {31'd0, busA.o_culled}, 32'd0);
  endtask

  initial begin
    int n, a0;
    busA.i_start = 0; busA.i_v1 = '0; busA.i_v2 = '0; busA.i_v3 = '0;
    busA.i_cull_mode = 0; busA.i_ready = 1;
    busB.i_start = 0; busB.i_v1 = '0; busB.i_v2 = '0; busB.i_v3 = '0;
    busB.i_cull_mode = 0; busB.i_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_done",   {31'd0, busA.o_done},   32'd1);
    chk("rst_valid",  {31'd0, busA.o_valid},  32'd0);
    chk("rst_culled", {31'd0, busA.o_culled}, 32'd0);
    chk("rst_point",  busA.o_point,           32'd0);
    mon_en = 1'b1;

    // Top-left fill, W<0 winding
    push10();
    start_tri(0, mkv(0, 0), mkv(4, 0), mkv(0, 4), 2'd0);
    wait_done(0, 100, n);
    chk("tl_done_cycle", n, 21);
    chk("tl_queue_empty", qA.size(), 0);

    // Strict interior
    qB.push_back({16'd1, 16'd1});
    qB.push_back({16'd1, 16'd2});
    qB.push_back({16'd2, 16'd1});
    start_tri(1, mkv(0, 0), mkv(4, 0), mkv(0, 4), 2'd0);
    wait_done(1, 100, n);
    chk("strict_done_cycle", n, 21);
    chk("strict_queue_empty", qB.size(), 0);

    // Reversed winding (W>0): no cull, and mode 3 behaves as no cull
    push10();
    start_tri(0, mkv(0, 0), mkv(0, 4), mkv(4, 0), 2'd0);
    wait_done(0, 100, n);
    chk("ccw_done_cycle", n, 21);
    chk("ccw_queue_empty", qA.size(), 0);
    push10();
    start_tri(0, mkv(0, 0), mkv(0, 4), mkv(4, 0), 2'd3);
    wait_done(0, 100, n);
    chk("mode3_queue_empty", qA.size(), 0);

    // Culling by sign and degenerate
    start_tri(0, mkv(0, 0), mkv(0, 4), mkv(4, 0), 2'd1);
    expect_culled("cull_wpos");
    start_tri(0, mkv(0, 0), mkv(4, 0), mkv(0, 4), 2'd2);
    expect_culled("cull_wneg");
    start_tri(0, mkv(0, 0), mkv(2, 2), mkv(4, 4), 2'd0);
    expect_culled("collinear");

    // Off-screen: empty box, no cull
    start_tri(0, mkv(700, 0), mkv(720, 0), mkv(700, 20), 2'd0);
    wait_done(0, 100, n);
    chk("offscreen_done_cycle", n, 4);
    chk("offscreen_culled", {31'd0, busA.o_culled}, 32'd0);

    // Backpressure
    push10();
    a0 = acc[0];
    start_tri(0, mkv(0, 0), mkv(4, 0), mkv(0, 4), 2'd0);
    fork
      wait_done(0, 300, n);
      begin : bp
        int k;
        k = 0;
        while (!busA.o_valid && k < 100) begin @(posedge clk); #1; k++; end
        busA.i_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        k = 0;
        while (!busA.o_done && k < 200) begin
          busA.i_ready = ~busA.i_ready;
          @(posedge clk); #1;
          k++;
        end
        busA.i_ready = 1'b1;
      end
    join
    chk("bp_done", {31'd0, busA.o_done}, 32'd1);
    chk("bp_accepted", acc[0] - a0, 10);
    chk("bp_queue_empty", qA.size(), 0);

    // Reset mid-scan, then a clean rerun
    push10();
    start_tri(0, mkv(0, 0), mkv(4, 0), mkv(0, 4), 2'd0);
    repeat (6) @(posedge clk);
    #1;
    mon_en = 1'b0;
    qA.delete();
    held[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_done",  {31'd0, busA.o_done},  32'd1);
    chk("midrst_valid", {31'd0, busA.o_valid}, 32'd0);
    chk("midrst_point", busA.o_point,          32'd0);
    mon_en = 1'b1;
    push10();
    start_tri(0, mkv(0, 0), mkv(4, 0), mkv(0, 4), 2'd0);
    wait_done(0, 100, n);
    chk("rerun_done_cycle", n, 21);
    chk("rerun_queue_empty", qA.size(), 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tri_raster_stream.md
# tri_raster_stream

Parametrised triangle scan converter for the GPU raster path. Takes three sub-pixel fixed-point vertices and emits every covered integer pixel of the screen-clipped bounding box in row-major order. Successor to the single-mode point generator, adding:
- configurable coordinate width and fraction bits;
- valid/ready backpressure on the pixel stream;
- selectable back-face culling;
- optional top-left fill rule;
- empty-box and degenerate-triangle handling.

Sits between vertex setup and the framebuffer write arbiter.

## Interface
- COORD_W, 32: signed width of each vertex coordinate.
- FRAC_BITS, 4: fractional bits of vertex coordinates.
- SCREEN_WIDTH, 640: exclusive x clip limit, in pixels.
- SCREEN_HEIGHT, 480: exclusive y clip limit, in pixels.
- TOP_LEFT, 1: 1 applies the top-left fill rule; 0 requires strict interior.
- i_clk  in  1  clock; one clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  start request; accepted only when o_done=1.
- i_v1, i_v2, i_v3  in  2*COORD_W each  {y, x}, signed fixed point.
- i_cull_mode  in  2  0 = no cull; 1 = cull W>0; 2 = cull W<0; 3 = treated as 0. Sampled with i_start.
- o_done  out  1  high when idle; reset value 1.
- o_culled  out  1  one-cycle pulse when a triangle is rejected; reset value 0.
- o_valid  out  1  o_point holds a covered pixel; reset value 0.
- i_ready  in  1  consumer accepts o_point on a cycle where o_valid && i_ready.
- o_point  out  32  {y[15:0], x[15:0]}, integer pixel coordinates; reset value 0.

## Operation
- **States:** IDLE → SETUP → ORDER → INIT → SCAN → DRAIN → IDLE.
- **IDLE.**
  - On i_start: latch vertices and i_cull_mode, drive o_done=0, go to SETUP.
  - i_start in any other state is ignored.
- **SETUP.**
  - Compute W = (y2-y1)*(x3-x2) - (x2-x1)*(y3-y2) at 2*COORD_W width.
  - The triangle is culled if W==0, or if i_cull_mode matches the sign of W.
  - Culled: o_culled=1 for one cycle, return to IDLE, o_done=1. No pixels are emitted.
- **ORDER.**
  - If W>0, swap v2 and v3, so the interior has positive edge values.
- **INIT.**
  - Bounding box, with F = FRAC_BITS:
    - minx = max(ceil(min x), 0); miny = max(ceil(min y), 0).
    - maxx = min(ceil(max x), SCREEN_WIDTH); maxy = min(ceil(max y), SCREEN_HEIGHT).
    - ceil(v) = (v + 2^F - 1) >>> F, arithmetic shift.
  - If minx ≥ maxx or miny ≥ maxy: go to IDLE, o_done=1. No pixels, no o_culled.
  - Otherwise load the edge accumulators. For edge i (i,j) in {(1,2),(2,3),(3,1)}:
    - E_i = dx*((miny<<F) - yi) - dy*((minx<<F) - xi), where dx = xj-xi and dy = yj-yi.
    - Accumulators are signed, 2*COORD_W wide.
  - Load (x, y) = (minx, miny).
- **SCAN.** Evaluates one pixel per non-stalled cycle.
  - Coverage: every E_i > 0, or E_i == 0 with TOP_LEFT=1 and edge i owned.
  - Edge i is owned iff dy<0, or dy==0 and dx>0.
  - Stepping in x: E_i -= dy<<F.
  - Row end (x+1 == maxx): x returns to minx, y increments, and every E_i is set to its row-start value + (dx<<F).
  - A covered pixel registers o_point and sets o_valid=1.
- **Stall.** While o_valid && !i_ready, all scan state, o_point and o_valid hold. No pixel is skipped or duplicated.
- **Last pixel.** After evaluating (maxx-1, maxy-1), go to DRAIN.
- **DRAIN.** Wait until o_valid=0 or a handshake completes, then go to IDLE with o_done=1.
- **Reset.** i_rst in any state returns to IDLE: o_done=1, o_valid=0, o_culled=0, o_point=0. Any in-flight triangle is dropped.

## Timing
- Start sampled at cycle 0.
  - Cycles 1, 2, 3: SETUP, ORDER, INIT.
  - First SCAN evaluation at cycle 4.
  - Earliest o_valid at cycle 5.
- Culled triangle: o_culled high in cycle 2, o_done high in cycle 2.
- Empty bounding box: o_done high in cycle 4.
- Unstalled scan takes exactly (maxx-minx)*(maxy-miny) SCAN cycles.
- o_done rises no earlier than the cycle after the final accepted pixel.
- i_start arriving in the same cycle as o_done rising is accepted on that cycle.

## Test plan
- **Top-left fill.** Vertices (0,0), (4,0), (0,4) in pixels (×16), TOP_LEFT=1, i_ready=1.
  - Exactly 10 pixels, those with x+y<4, in row-major order.
  - First pixel (0,0), last pixel (0,3).
  - o_done rises 16 SCAN cycles after INIT.
- **Strict interior.** Same triangle with TOP_LEFT=0 → only (1,1), (2,1), (1,2).
- **Winding and culling.** Same triangle with vertex order (0,0), (0,4), (4,0), which gives W>0.
  - i_cull_mode=0 → the same 10 pixels.
  - i_cull_mode=1 → o_culled pulse in cycle 2, no o_valid.
- **Backpressure.** First triangle; drop i_ready for 5 cycles after the first o_valid, then toggle it every cycle.
  - o_point stays stable while stalled.
  - Exactly 10 unique pixels accepted, in order.
- **Degenerate and clipped inputs.**
  - Collinear (0,0), (2,2), (4,4) → culled.
  - Triangle with every x ≥ 700 px → o_done in cycle 4, zero pixels.
- **Reset mid-scan.** Assert i_rst during SCAN.
  - Next cycle: o_done=1, o_valid=0, o_point=0.
  - A following i_start rasterizes from scratch correctly.
